// File: rtl/instruction_fetch_controller_if.sv
// instruction_fetch_controller_if: control, branch, memory and instruction-stream signals of the fetch controller
interface instruction_fetch_controller_if #(
  parameter int INSTRUCTION_SIZE      = 16,
  parameter int INSTRUCTION_ADDR_SIZE = 10
);
  logic                             start;
  logic                             halt;
  logic                             branch_valid;
  logic [INSTRUCTION_ADDR_SIZE-1:0] branch_target;
  logic [INSTRUCTION_ADDR_SIZE-1:0] imem_addr;
  logic [INSTRUCTION_SIZE-1:0]      imem_data;
  logic [INSTRUCTION_SIZE-1:0]      instr;
  logic [INSTRUCTION_ADDR_SIZE-1:0] instr_pc;
  logic                             instr_valid;
  logic                             instr_ready;
  logic                             running;
  modport master (
    input  start, halt, branch_valid, branch_target, imem_data, instr_ready,
    output imem_addr, instr, instr_pc, instr_valid, running
  );
  modport slave (
    output start, halt, branch_valid, branch_target, imem_data, instr_ready,
    input  imem_addr, instr, instr_pc, instr_valid, running
  );
endinterface

// File: rtl/instruction_fetch_controller.sv
// instruction_fetch_controller: IDLE/RUN fetch sequencer feeding a one-entry instruction register from combinational memory.
// Optional FETCH_HALT_ON_ZERO_EN: an all-zero fetched word stops the controller instead of being presented.
module instruction_fetch_controller #(
  parameter int INSTRUCTION_SIZE      = 16,
  parameter int INSTRUCTION_ADDR_SIZE = 10,
  parameter int RESET_VECTOR          = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  instruction_fetch_controller_if.master bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                           r_state, w_state;
  logic [INSTRUCTION_ADDR_SIZE-1:0] r_pc, w_pc;
  logic [INSTRUCTION_SIZE-1:0]      r_instr, w_instr;
  logic [INSTRUCTION_ADDR_SIZE-1:0] r_instr_pc, w_instr_pc;
  logic                             r_valid, w_valid;
  logic                             w_fetch;
  assign bus.imem_addr   = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_valid;
  assign bus.running     = r_state == RUN;
  // A fetch needs the output register to be empty or drained this cycle
  assign w_fetch = r_state == RUN && (!r_valid || bus.instr_ready);
  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_instr    = r_instr;
    w_instr_pc = r_instr_pc;
    w_valid    = r_valid;
    if (bus.halt) begin
      w_state = IDLE;
      w_valid = 1'b0;
    end else if (bus.branch_valid) begin
      w_pc    = bus.branch_target;
      w_valid = 1'b0;
    end else if (r_state == IDLE) begin
      w_state = bus.start ? RUN : IDLE;
    end else if (w_fetch) begin
`ifdef FETCH_HALT_ON_ZERO_EN
      if (bus.imem_data == '0) begin
        w_state = IDLE;
        w_valid = 1'b0;
      end else begin
        w_instr    = bus.imem_data;
        w_instr_pc = r_pc;
        w_valid    = 1'b1;
        w_pc       = r_pc + 1'b1;
      end
`else
      w_instr    = bus.imem_data;
      w_instr_pc = r_pc;
      w_valid    = 1'b1;
      w_pc       = r_pc + 1'b1;
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pc       <= INSTRUCTION_ADDR_SIZE'(RESET_VECTOR);
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_instr    <= w_instr;
      r_instr_pc <= w_instr_pc;
      r_valid    <= w_valid;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_controller.sv
// tb_instruction_fetch_controller: directed checks of fetch, stall, branch, wrap, halt/resume, reset and zero-word handling
module tb_instruction_fetch_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [15:0] mem [1024];
  instruction_fetch_controller_if #(.INSTRUCTION_SIZE(16), .INSTRUCTION_ADDR_SIZE(10)) bus ();
  instruction_fetch_controller #(.INSTRUCTION_SIZE(16), .INSTRUCTION_ADDR_SIZE(10), .RESET_VECTOR(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.imem_data = mem[bus.imem_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic word(input string tag, input int pc);
    chk({tag, " valid"}, 32'(bus.instr_valid), 1);
    chk({tag, " pc"}, 32'(bus.instr_pc), 32'(pc));
    chk({tag, " instr"}, 32'(bus.instr), 32'(mem[pc]));
  endtask
  task automatic branch(input int tgt);
    bus.branch_valid = 1'b1;
    bus.branch_target = 10'(tgt);
    step();
    bus.branch_valid = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 1);
    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_target = '0;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("rst running", 32'(bus.running), 0);
    chk("rst valid", 32'(bus.instr_valid), 0);
    chk("rst addr", 32'(bus.imem_addr), 0);
    chk("rst instr", 32'(bus.instr), 0);
    chk("rst pc", 32'(bus.instr_pc), 0);
    rst = 1'b0;
    step();
    chk("idle stays", 32'(bus.running), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("run entry", 32'(bus.running), 1);
    chk("run entry valid", 32'(bus.instr_valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      word("seq", i);
    end
    bus.branch_valid = 1'b1;
    bus.branch_target = 10'd30;
    step();
    bus.branch_valid = 1'b0;
    chk("branch bubble", 32'(bus.instr_valid), 0);
    step();
    word("br30", 30);
    step();
    word("br31", 31);
    branch(5);
    step();
    word("pre stall", 5);
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      word("stall", 5);
      chk("stall addr", 32'(bus.imem_addr), 6);
    end
    bus.instr_ready = 1'b1;
    step();
    word("release", 6);
    branch(1023);
    chk("wrap bubble", 32'(bus.instr_valid), 0);
    step();
    word("wrap 1023", 1023);
    step();
    word("wrap 0", 0);
    branch(46);
    step();
    word("pre halt", 46);
    bus.halt = 1'b1;
    step();
    bus.halt = 1'b0;
    chk("halt running", 32'(bus.running), 0);
    chk("halt valid", 32'(bus.instr_valid), 0);
    chk("halt addr", 32'(bus.imem_addr), 47);
    step();
    chk("halt idle", 32'(bus.running), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("resume valid", 32'(bus.instr_valid), 0);
    step();
    word("resume", 47);
    bus.instr_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async running", 32'(bus.running), 0);
    chk("async valid", 32'(bus.instr_valid), 0);
    chk("async addr", 32'(bus.imem_addr), 0);
    chk("async pc", 32'(bus.instr_pc), 0);
    @(negedge clk);
    mem[3] = 16'h0000;
    bus.instr_ready = 1'b1;
    rst = 1'b0;
    step();
    chk("after rst idle", 32'(bus.running), 0);
    bus.branch_valid = 1'b1;
    bus.branch_target = 10'd0;
    step();
    bus.branch_valid = 1'b0;
    chk("idle branch", 32'(bus.running), 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      word("zseq", i);
    end
    step();
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("zero running", 32'(bus.running), 0);
    chk("zero valid", 32'(bus.instr_valid), 0);
    chk("zero addr", 32'(bus.imem_addr), 3);
`else
    chk("zero running", 32'(bus.running), 1);
    word("zero word", 3);
    chk("zero instr", 32'(bus.instr), 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 SHALL have parameter INSTRUCTION_SIZE, default 16, meaning instruction word width in bits.
REQ-002 SHALL have parameter INSTRUCTION_ADDR_SIZE, default 10, meaning instruction address width in bits.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, meaning PC value after reset.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, meaning leave IDLE and begin fetching.
REQ-007 SHALL have port halt, input, 1, meaning stop fetching and return to IDLE.
REQ-008 SHALL have port branch_valid, input, 1, meaning redirect the PC this cycle.
REQ-009 SHALL have port branch_target, input, INSTRUCTION_ADDR_SIZE, meaning redirect address.
REQ-010 SHALL have port imem_addr, output, INSTRUCTION_ADDR_SIZE, meaning address to the combinational instruction memory.
REQ-011 SHALL have port imem_data, input, INSTRUCTION_SIZE, meaning memory read data for imem_addr, same cycle.
REQ-012 SHALL have port instr, output, INSTRUCTION_SIZE, meaning registered fetched instruction.
REQ-013 SHALL have port instr_pc, output, INSTRUCTION_ADDR_SIZE, meaning address instr was fetched from.
REQ-014 SHALL have port instr_valid, output, 1, meaning instr/instr_pc hold a valid word.
REQ-015 SHALL have port instr_ready, input, 1, meaning consumer accepts instr this cycle.
REQ-016 SHALL have port running, output, 1, meaning state is RUN.

Function
REQ-017 SHALL implement two states, IDLE and RUN; running = (state == RUN).
REQ-018 SHALL drive imem_addr combinationally from the PC register.
REQ-019 SHALL assign per-edge priority: halt > branch_valid > start/fetch.
REQ-020 IDLE: start=1 and halt=0 and branch_valid=0 SHALL move to RUN; PC unchanged; no fetch in that cycle.
REQ-021 IDLE: branch_valid=1 SHALL load PC <= branch_target and remain IDLE.
REQ-022 RUN, no halt/branch, and (instr_valid=0 or instr_ready=1): SHALL load instr <= imem_data, instr_pc <= PC, instr_valid <= 1, PC <= PC+1 (one-cycle fetch latency, one word per cycle).
REQ-023 RUN, instr_valid=1 and instr_ready=0: SHALL hold instr, instr_pc, instr_valid and PC unchanged (stall).
REQ-024 RUN, branch_valid=1: SHALL set PC <= branch_target and instr_valid <= 0, discarding any held word (one-cycle bubble); word at target presented the following cycle.
REQ-025 halt=1 in any state: SHALL set state <= IDLE and instr_valid <= 0; PC SHALL keep the next unfetched address so a later start resumes there.
REQ-026 PC increment SHALL wrap modulo 2^INSTRUCTION_ADDR_SIZE (max address -> 0).
REQ-027 A word accepted (instr_valid & instr_ready) in the same cycle as branch_valid or halt SHALL count as consumed; the controller SHALL NOT re-present it.

Reset
REQ-028 rst=1 SHALL asynchronously set state=IDLE, PC=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0, regardless of clk.
REQ-029 Reset asserted mid-RUN or mid-stall SHALL discard the held word; fetching resumes only after a new start.

Configuration
REQ-030 With FETCH_HALT_ON_ZERO_EN defined, a fetch per REQ-022 whose imem_data is all zeros SHALL NOT be presented: instr_valid <= 0, state <= IDLE, PC unchanged (points at the zero word).
REQ-031 Without FETCH_HALT_ON_ZERO_EN, an all-zero word SHALL be fetched and presented like any other.

Verification
REQ-032 Reset, start, instr_ready=1, memory word[n]=n+1 -> instr 1,2,3 on consecutive cycles with instr_pc 0,1,2, first valid one cycle after RUN entry.
REQ-033 instr_ready=0 for 3 cycles while instr_pc=5 -> instr, instr_pc=5, imem_addr=6 stable all 3 cycles; release -> instr_pc 6 next cycle.
REQ-034 branch_valid=1, branch_target=30 while instr_pc=2 -> instr_valid=0 next cycle, then instr_pc=30, then 31.
REQ-035 branch to 1023 then run -> instr_pc 1023 followed by instr_pc 0.
REQ-036 halt at instr_pc=46, then start -> running=0, instr_valid=0; after start next word presented has instr_pc=47.
REQ-037 With FETCH_HALT_ON_ZERO_EN, zero word at address 3 -> words 0..2 presented, then running=0, instr_valid=0, imem_addr=3; without macro, word 3 presented with instr=0.
